adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder_pkg.sv | 10 +
 rtl/full_adder.sv | 16 +
 rtl/adder.sv | 53 +++++
 tb/tb_adder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the ripple-carry adder slice.
// Holds the carry-generation rule used by every full-adder cell.
package adder_pkg;

  // Majority-of-three: the carry out of a single full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell: purely combinational sum and carry.
// Chained by the adder top to form a ripple-carry adder.
module full_adder
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/adder.sv
// Parameterised ripple-carry adder: {cout, s} = a + b + cin.
// With REG_OUT=1 the result is held in an output register that uses a synchronous, active-low reset.
module adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is tested inside the clocked branch,
    // which makes it synchronous and gives it priority over operand capture.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s    <= '0;
        cout <= 1'b0;
      end else begin
        s    <= sum;
        cout <= carry[WIDTH];
      end
    end
  end else begin : g_comb
    assign s    = sum;
    assign cout = carry[WIDTH];

    // Stateless variant: clk and rst are intentionally left without effect.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: combinational and registered variants at several widths.
// Expected values come from plain integer arithmetic on the applied operands.
module tb_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r4 = 1'b0;
  logic r8 = 1'b0;

  logic       a1, b1, ci1, s1, c1;
  logic [3:0] a4c, b4c, s4c;
  logic       ci4c, c4c;
  logic [3:0] a4r, b4r, s4r;
  logic       ci4r, c4r;
  logic [7:0] a8, b8, s8;
  logic       ci8, c8;

  int checks = 0;
  int errors = 0;

  adder #(.WIDTH(1), .REG_OUT(0)) u_w1 (
    .clk(clk), .rst(r4), .a(a1), .b(b1), .cin(ci1), .s(s1), .cout(c1));
  adder #(.WIDTH(4), .REG_OUT(0)) u_w4c (
    .clk(clk), .rst(r4), .a(a4c), .b(b4c), .cin(ci4c), .s(s4c), .cout(c4c));
  adder #(.WIDTH(4), .REG_OUT(1)) u_w4r (
    .clk(clk), .rst(r4), .a(a4r), .b(b4r), .cin(ci4r), .s(s4r), .cout(c4r));
  adder #(.WIDTH(8), .REG_OUT(1)) u_w8r (
    .clk(clk), .rst(r8), .a(a8), .b(b8), .cin(ci8), .s(s8), .cout(c8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden {cout, s} for a WIDTH-bit add, zero-extended.
  function automatic logic [63:0] golden(input int w, input logic [63:0] x,
                                         input logic [63:0] y, input logic c);
    logic [64:0] full;
    full = 65'(x) + 65'(y) + 65'(c);
    full = full & ((65'd1 << (w + 1)) - 65'd1);
    return full[63:0];
  endfunction

  initial begin
    logic [1:0]  w1_table [8];
    logic [2:0]  vec;
    logic [63:0] exp8;

    // {s, cout} for {a, b, cin} = 000..111
    w1_table = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    a1 = 0; b1 = 0; ci1 = 0;
    a4c = 0; b4c = 0; ci4c = 0;
    a4r = 0; b4r = 0; ci4r = 0;
    a8 = 0; b8 = 0; ci8 = 0;

    // Width-1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {a1, b1, ci1} = vec;
      #1;
      check($sformatf("w1_vec%0d", i), 64'({s1, c1}), 64'(w1_table[i]));
    end

    // Width-4 combinational boundary cases, with rst held low to show it is ignored.
    a4c = 4'hF; b4c = 4'h1; ci4c = 1'b0; #1;
    check("w4c_f_plus_1", 64'({c4c, s4c}), 64'(5'b1_0000));
    a4c = 4'h7; b4c = 4'h8; ci4c = 1'b1; #1;
    check("w4c_7_8_1", 64'({c4c, s4c}), 64'(5'b1_0000));
    for (int i = 0; i < 16; i++) begin
      a4c = 4'($urandom); b4c = 4'($urandom); ci4c = 1'($urandom); #1;
      check("w4c_rand", 64'({c4c, s4c}), golden(4, 64'(a4c), 64'(b4c), ci4c));
    end

    // Width-4 registered: reset for two edges clears the outputs.
    r4 = 1'b0;
    tick();
    tick();
    check("w4r_reset", 64'({c4r, s4r}), 64'd0);

    // Release reset and apply operands; result must appear exactly one edge later.
    r4 = 1'b1; a4r = 4'h3; b4r = 4'h4; ci4r = 1'b1;
    #1;
    check("w4r_pre_edge", 64'({c4r, s4r}), 64'd0);
    tick();
    check("w4r_first", 64'({c4r, s4r}), 64'(5'b0_1000));

    // In-flight F+F+1 is discarded by a reset on the capturing edge.
    a4r = 4'hF; b4r = 4'hF; ci4r = 1'b1; r4 = 1'b0;
    tick();
    check("w4r_discard0", 64'({c4r, s4r}), 64'd0);
    a4r = 4'h2; b4r = 4'h5; ci4r = 1'b0;
    tick();
    check("w4r_discard1", 64'({c4r, s4r}), 64'd0);
    r4 = 1'b1;
    tick();
    check("w4r_resume", 64'({c4r, s4r}), 64'(5'b0_0111));

    // Width-8 registered: 1000 back-to-back random operations.
    r8 = 1'b0;
    tick();
    check("w8r_reset", 64'({c8, s8}), 64'd0);
    r8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    exp8 = golden(8, 64'(a8), 64'(b8), ci8);
    for (int i = 0; i < 1000; i++) begin
      tick();
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      check($sformatf("w8r_cyc%0d", i), 64'({c8, s8}), exp8);
      exp8 = golden(8, 64'(a8), 64'(b8), ci8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
